// File: rtl/wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_rr
// Brief    : Round-robin single-beat Wishbone arbiter with per-transfer watchdog
// Revision : 1.0
// ============================================================================
module wb_arbiter_rr #(
    parameter int          M        = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hffffffff
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [16*M-1:0]       m_addr,
    input  logic [32*M-1:0]       m_wdata,
    input  logic [M-1:0]          m_we,
    input  logic [M-1:0]          m_cyc,
    output logic [31:0]           m_rdata,
    output logic [M-1:0]          m_ack,
    output logic [15:0]           s_addr,
    output logic [31:0]           s_wdata,
    output logic                  s_we,
    output logic                  s_cyc,
    input  logic [31:0]           s_rdata,
    input  logic                  s_ack,
    output logic                  err_flag,
    output logic [$clog2(M)-1:0]  err_master,
    input  logic                  err_clr
);

    localparam int c_IDX_W = $clog2(M);
    localparam int c_CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_TOUT = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_gnt;
    logic [c_IDX_W-1:0] r_last;
    logic [c_IDX_W-1:0] w_pick;
    logic [c_IDX_W-1:0] w_scan_idx;
    logic               w_req_any;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_cnt_hit;
    logic               r_err_flag;
    logic [c_IDX_W-1:0] r_err_master;

    // Scan from the highest offset down so the nearest requester after r_last wins.
    always_comb begin
        w_req_any  = |m_cyc;
        w_pick     = r_last;
        w_scan_idx = r_last;
        for (int k = M; k >= 1; k--) begin
            w_scan_idx = c_IDX_W'((int'(r_last) + k) % M);
            if (m_cyc[w_scan_idx]) begin
                w_pick = w_scan_idx;
            end
        end
    end

    assign w_cnt_hit = (TIMEOUT != 0) && (r_cnt == c_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_gnt        <= '0;
            r_last       <= c_IDX_W'(M - 1);
            r_cnt        <= '0;
            r_err_flag   <= 1'b0;
            r_err_master <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_S_IDLE && w_req_any) begin
                r_gnt  <= w_pick;
                r_last <= w_pick;
                r_cnt  <= '0;
            end
            // Saturating so a disabled watchdog never wraps into a false hit.
            if (r_state == c_S_BUSY && r_cnt != '1) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (r_state == c_S_TOUT) begin
                r_err_flag   <= 1'b1;
                r_err_master <= r_gnt;
            end else if (err_clr) begin
                r_err_flag   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = c_S_BUSY;
                end
            end
            c_S_BUSY: begin
                if (s_ack) begin
                    w_state_nxt = c_S_IDLE;
                end else if (!m_cyc[r_gnt]) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_cnt_hit) begin
                    w_state_nxt = c_S_TOUT;
                end
            end
            c_S_TOUT: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        s_cyc   = 1'b0;
        s_addr  = m_addr[16*r_gnt +: 16];
        s_wdata = m_wdata[32*r_gnt +: 32];
        s_we    = m_we[r_gnt];
        m_ack   = '0;
        m_rdata = s_rdata;
        case (r_state)
            c_S_BUSY: begin
                s_cyc        = m_cyc[r_gnt];
                m_ack[r_gnt] = s_ack;
            end
            c_S_TOUT: begin
                m_ack[r_gnt] = 1'b1;
                m_rdata      = ERR_DATA;
            end
            default: begin
                s_cyc = 1'b0;
            end
        endcase
    end

    assign err_flag   = r_err_flag;
    assign err_master = r_err_master;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter_rr
// Brief    : Directed and randomized bench for wb_arbiter_rr (M=3, TIMEOUT=4)
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter_rr;

    localparam int          P_M   = 3;
    localparam int          P_IW  = 2;
    localparam int          P_TO  = 4;
    localparam logic [31:0] P_ERR = 32'hffffffff;

    logic               clk = 1'b0;
    logic               rst;
    logic [16*P_M-1:0]  m_addr;
    logic [32*P_M-1:0]  m_wdata;
    logic [P_M-1:0]     m_we;
    logic [P_M-1:0]     m_cyc;
    logic [31:0]        m_rdata;
    logic [P_M-1:0]     m_ack;
    logic [15:0]        s_addr;
    logic [31:0]        s_wdata;
    logic               s_we;
    logic               s_cyc;
    logic [31:0]        s_rdata;
    logic               s_ack;
    logic               err_flag;
    logic [P_IW-1:0]    err_master;
    logic               err_clr;

    always #5 clk = ~clk;

    wb_arbiter_rr #(.M(P_M), .TIMEOUT(P_TO), .ERR_DATA(P_ERR)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_we       (m_we),
        .m_cyc      (m_cyc),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_we       (s_we),
        .s_cyc      (s_cyc),
        .s_rdata    (s_rdata),
        .s_ack      (s_ack),
        .err_flag   (err_flag),
        .err_master (err_master),
        .err_clr    (err_clr)
    );

    // Bench-side master/slave intent, applied at each falling edge.
    logic           rst_v;
    logic [P_M-1:0] req;
    logic [P_M-1:0] cool;
    logic [P_M-1:0] auto_mask;
    logic [15:0]    addr_q  [P_M];
    logic [31:0]    wdata_q [P_M];
    logic           we_q    [P_M];
    logic           s_ack_v;
    logic [31:0]    s_rdata_v;
    logic           err_clr_v;

    logic           obs_cyc;
    logic [P_M-1:0] obs_ack;
    logic [31:0]    obs_rdata;
    logic [15:0]    obs_addr;
    logic           obs_errf;
    logic [P_IW-1:0] obs_errm;

    // Transaction-level reference: who owns the bus, how long it has waited.
    int md_owner;
    int md_waited;
    int md_last;
    int md_errm;
    bit md_tout;
    bit md_errf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        md_owner  = -1;
        md_waited = 0;
        md_last   = P_M - 1;
        md_errm   = 0;
        md_tout   = 1'b0;
        md_errf   = 1'b0;
    endtask

    task automatic model_step();
        int j;
        if (rst_v) begin
            model_reset();
        end else if (md_tout) begin
            md_errf  = 1'b1;
            md_errm  = md_owner;
            md_tout  = 1'b0;
            md_owner = -1;
        end else begin
            if (err_clr_v) md_errf = 1'b0;
            if (md_owner < 0) begin
                for (int k = 1; k <= P_M; k++) begin
                    j = (md_last + k) % P_M;
                    if (req[P_IW'(j)]) begin
                        md_owner  = j;
                        md_last   = j;
                        md_waited = 0;
                        break;
                    end
                end
            end else begin
                md_waited++;
                if (s_ack_v || !req[P_IW'(md_owner)]) md_owner = -1;
                else if (md_waited == P_TO) md_tout = 1'b1;
            end
        end
    endtask

    task automatic run_cycle();
        logic [P_M-1:0] e_ack;
        logic           e_cyc;
        logic [31:0]    e_rdata;
        @(negedge clk);
        rst     = rst_v;
        err_clr = err_clr_v;
        s_ack   = s_ack_v;
        s_rdata = s_rdata_v;
        for (int i = 0; i < P_M; i++) begin
            m_cyc[i]            = req[i];
            m_we[i]             = we_q[i];
            m_addr[16*i +: 16]  = addr_q[i];
            m_wdata[32*i +: 32] = wdata_q[i];
        end
        #1;
        e_ack   = '0;
        e_cyc   = 1'b0;
        e_rdata = s_rdata_v;
        if (md_owner >= 0) begin
            if (md_tout) begin
                e_ack[md_owner] = 1'b1;
                e_rdata         = P_ERR;
            end else begin
                e_cyc           = req[md_owner];
                e_ack[md_owner] = s_ack_v;
            end
        end
        check("s_cyc", s_cyc, e_cyc);
        check("m_ack", m_ack, e_ack);
        if (e_ack != '0) check("m_rdata", m_rdata, e_rdata);
        if (e_cyc) begin
            check("s_addr", s_addr, addr_q[md_owner]);
            check("s_wdata", s_wdata, wdata_q[md_owner]);
            check("s_we", s_we, we_q[md_owner]);
        end
        check("err_flag", err_flag, md_errf);
        check("err_master", err_master, md_errm);
        obs_cyc   = s_cyc;
        obs_ack   = m_ack;
        obs_rdata = m_rdata;
        obs_addr  = s_addr;
        obs_errf  = err_flag;
        obs_errm  = err_master;
        model_step();
        for (int i = 0; i < P_M; i++) begin
            if (e_ack[i]) begin
                req[i]  = 1'b0;
                cool[i] = 1'b1;
            end else begin
                cool[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        req   = '0;
        rst_v = 1'b1;
        run_cycle();
        rst_v = 1'b0;
    endtask

    task automatic stim_auto();
        for (int i = 0; i < P_M; i++) begin
            if (auto_mask[i] && !req[i] && !cool[i]) req[i] = 1'b1;
        end
    endtask

    task automatic stim_random(input int ack_pct);
        s_ack_v   = ($urandom_range(0, 99) < ack_pct);
        s_rdata_v = $urandom;
        err_clr_v = ($urandom_range(0, 19) == 0);
        rst_v     = ($urandom_range(0, 699) == 0);
        for (int i = 0; i < P_M; i++) begin
            if (!req[i]) begin
                if (!cool[i] && $urandom_range(0, 2) == 0) begin
                    req[i]     = 1'b1;
                    addr_q[i]  = 16'($urandom);
                    wdata_q[i] = $urandom;
                    we_q[i]    = 1'($urandom);
                end
            end else if ($urandom_range(0, 39) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit   got;
        int   cnt;
        int   ord[$];
        int   pcts[4];

        pcts = '{0, 15, 50, 95};
        req = '0; cool = '0; auto_mask = '0;
        for (int i = 0; i < P_M; i++) begin
            addr_q[i]  = 16'h1000 * 16'(i + 1);
            wdata_q[i] = 32'h0;
            we_q[i]    = 1'b0;
        end
        s_ack_v = 1'b0; s_rdata_v = '0; err_clr_v = 1'b0; rst_v = 1'b1;
        rst = 1'b1; m_cyc = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_rdata = '0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state
        run_cycle();
        check("rst_s_cyc", obs_cyc, 1'b0);
        check("rst_m_ack", obs_ack, '0);
        check("rst_err", obs_errf, 1'b0);
        rst_v = 1'b0;

        // Single read, slave acks two cycles after s_cyc rises
        req[0] = 1'b1; addr_q[0] = 16'h0010; we_q[0] = 1'b0;
        s_rdata_v = 32'h12345678;
        got = 1'b0; cnt = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            s_ack_v = (cnt == 2);
            run_cycle();
            if (obs_cyc) begin
                check("t1_addr", obs_addr, 16'h0010);
                cnt++;
            end
            if (obs_ack != '0) begin
                got = 1'b1;
                check("t1_ack", obs_ack, 3'b001);
                check("t1_rdata", obs_rdata, 32'h12345678);
                check("t1_latency", k + 1, 4);
            end
        end
        check("t1_done", got, 1'b1);
        s_ack_v = 1'b0;
        run_cycle();
        check("t1_idle", obs_cyc, 1'b0);

        // All masters requesting continuously, immediate acks
        do_reset();
        auto_mask = '1; s_ack_v = 1'b1;
        for (int k = 0; k < 40 && ord.size() < 6; k++) begin
            stim_auto();
            run_cycle();
            for (int i = 0; i < P_M; i++) if (obs_ack[i]) ord.push_back(i);
        end
        check("t2_count", ord.size(), 6);
        for (int j = 0; j < ord.size(); j++) check($sformatf("t2_order%0d", j), ord[j], j % P_M);
        auto_mask = '0; s_ack_v = 1'b0;
        do_reset();

        // Timeout on master 1 write
        req[1] = 1'b1; we_q[1] = 1'b1; addr_q[1] = 16'h0200; wdata_q[1] = 32'hcafef00d;
        got = 1'b0; cnt = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            run_cycle();
            if (obs_cyc) cnt++;
            if (obs_ack != '0) begin
                got = 1'b1;
                check("t3_ack", obs_ack, 3'b010);
                check("t3_rdata", obs_rdata, P_ERR);
                check("t3_cyc_low", obs_cyc, 1'b0);
            end
        end
        check("t3_done", got, 1'b1);
        check("t3_cyc_len", cnt, P_TO);
        run_cycle();
        check("t3_err_flag", obs_errf, 1'b1);
        check("t3_err_master", obs_errm, 2'd1);
        err_clr_v = 1'b1;
        run_cycle();
        err_clr_v = 1'b0;
        run_cycle();
        check("t3_err_clr", obs_errf, 1'b0);

        // Ack on the last cycle before the watchdog fires
        req[0] = 1'b1; addr_q[0] = 16'h0300; we_q[0] = 1'b0; s_rdata_v = 32'h5a5a0001;
        got = 1'b0; cnt = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            s_ack_v = (cnt == P_TO - 1);
            run_cycle();
            if (obs_cyc) cnt++;
            if (obs_ack != '0) begin
                got = 1'b1;
                check("t4_ack", obs_ack, 3'b001);
                check("t4_rdata", obs_rdata, 32'h5a5a0001);
            end
        end
        s_ack_v = 1'b0;
        check("t4_done", got, 1'b1);
        check("t4_cyc_len", cnt, P_TO);
        run_cycle();
        check("t4_no_err", obs_errf, 1'b0);

        // Master 0 aborts, pending master 1 granted after one idle cycle
        req[0] = 1'b1; addr_q[0] = 16'h1000; addr_q[1] = 16'h2000;
        run_cycle();
        check("t5_idle0", obs_cyc, 1'b0);
        req[1] = 1'b1;
        run_cycle();
        check("t5_busy0", obs_cyc, 1'b1);
        check("t5_addr0", obs_addr, 16'h1000);
        req[0] = 1'b0;
        run_cycle();
        check("t5_abort_cyc", obs_cyc, 1'b0);
        check("t5_abort_ack", obs_ack, '0);
        run_cycle();
        check("t5_gap", obs_cyc, 1'b0);
        run_cycle();
        check("t5_busy1", obs_cyc, 1'b1);
        check("t5_addr1", obs_addr, 16'h2000);
        s_ack_v = 1'b1;
        run_cycle();
        s_ack_v = 1'b0;
        run_cycle();

        // Reset while busy clears the error and restores master 0 priority
        req[2] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            run_cycle();
            if (obs_ack != '0) got = 1'b1;
        end
        check("t6_tout_done", got, 1'b1);
        run_cycle();
        check("t6_err_set", obs_errf, 1'b1);
        check("t6_err_master", obs_errm, 2'd2);
        req[1] = 1'b1;
        run_cycle();
        run_cycle();
        check("t6_busy", obs_cyc, 1'b1);
        rst_v = 1'b1; req[0] = 1'b1;
        run_cycle();
        rst_v = 1'b0;
        run_cycle();
        check("t6_rst_cyc", obs_cyc, 1'b0);
        check("t6_rst_err", obs_errf, 1'b0);
        run_cycle();
        check("t6_regrant_cyc", obs_cyc, 1'b1);
        check("t6_regrant_addr", obs_addr, addr_q[0]);
        do_reset();

        // Randomized traffic with rotating slave responsiveness
        for (int c = 0; c < 3000; c++) begin
            stim_random(pcts[(c / 250) % 4]);
            run_cycle();
        end
        rst_v = 1'b0; err_clr_v = 1'b0; s_ack_v = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Round-robin Wishbone arbiter that shares one slave-side bus between M masters. Typical masters are the UART/USB debug bridges (uart2wb, stream2wb) and an on-chip CPU.
- Single-beat transfers only, matching the bridge convention: a master holds cyc until it sees ack, then drops cyc on the next cycle.
- A per-transfer watchdog ends transfers the slave never acks, so a hung peripheral cannot lock the debug path.

Parameters:
- M, 2: number of masters (2..8).
- TIMEOUT, 255: cycles a granted transfer may wait for s_ack before forced termination. 0 disables the watchdog.
- ERR_DATA, 32'hffffffff: read data returned to the master on a timed-out transfer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- m_addr  in  16*M  master addresses, master i at [16*i+15:16*i].
- m_wdata  in  32*M  master write data, master i at [32*i+31:32*i].
- m_we  in  M  master write enables.
- m_cyc  in  M  master cycle requests.
- m_rdata  out  32  read data broadcast to all masters.
- m_ack  out  M  per-master acknowledge.
- s_addr  out  16  slave address.
- s_wdata  out  32  slave write data.
- s_we  out  1  slave write enable.
- s_cyc  out  1  slave cycle.
- s_rdata  in  32  slave read data.
- s_ack  in  1  slave acknowledge.
- err_flag  out  1  sticky flag, set when a timeout occurs.
- err_master  out  clog2(M)  index of the master whose transfer last timed out.
- err_clr  in  1  clears err_flag.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state IDLE, gnt=0, last=M-1 (so master 0 has top priority after reset), counter=0.
  - s_cyc=0, m_ack=0, err_flag=0, err_master=0.
  - s_addr/s_wdata/s_we are don't-care while s_cyc=0.
- States:
  - IDLE: if any m_cyc is high, pick the first requester scanning last+1, last+2, … modulo M. Register gnt and last=gnt, clear the counter, go to BUSY. Otherwise stay in IDLE.
  - BUSY:
    - Combinational outputs: s_cyc = m_cyc[gnt]; s_addr/s_wdata/s_we muxed from master gnt; m_ack[gnt] = s_ack; m_rdata = s_rdata. All other m_ack bits are 0.
    - If s_ack=1, go to IDLE.
    - Else if m_cyc[gnt]=0 (master abort), go to IDLE with no ack.
    - Else if TIMEOUT!=0 and the counter equals TIMEOUT-1, go to TOUT.
    - Otherwise increment the counter.
  - TOUT (exactly one cycle): s_cyc=0, m_ack[gnt]=1, m_rdata=ERR_DATA. Set err_flag and err_master=gnt, then go to IDLE.
- Latency:
  - A request seen in IDLE gives s_cyc in the next cycle.
  - The ack is passed through combinationally in the same cycle.
  - Minimum turnaround is 1 IDLE cycle between grants.
  - The master drops cyc in the cycle after ack, so it is low when IDLE arbitrates and cannot be re-granted spuriously.
- Timeout timing: with no ack, s_cyc is high for exactly TIMEOUT cycles, then the TOUT cycle follows.
- Simultaneous events:
  - s_ack in the same cycle the counter reaches TIMEOUT-1: s_ack wins and normal completion follows, with no error.
  - err_clr in the same cycle as a TOUT: set wins.
  - err_clr otherwise clears err_flag; err_master holds its value.
- Fairness:
  - Each master waits at most M-1 transfers when all masters request continuously.
  - `last` updates only on a grant.
- Counter width is clog2(TIMEOUT+1), or 1 when TIMEOUT=0. It saturates, never wraps.
- Reset mid-transfer: at the reset edge the arbiter returns to IDLE, s_cyc=0 from the next cycle, and any pending ack is dropped.
- Any s_ack arriving while not in BUSY is ignored.

Test Plan:
- M=2, master 0 reads 0x0010, slave acks 2 cycles after s_cyc -> s_cyc rises the cycle after m_cyc[0], s_addr=0x0010, m_ack=2'b01 in the ack cycle, m_rdata=s_rdata, IDLE one cycle.
- M=3, all m_cyc held and re-asserted after each ack, slave acks immediately -> grant order 0,1,2,0,1,2; no master granted twice in a row.
- TIMEOUT=4, master 1 write, slave never acks -> s_cyc high exactly 4 cycles, then m_ack=2'b10 with m_rdata=0xffffffff and s_cyc=0; err_flag=1, err_master=1; err_clr pulse -> err_flag=0.
- TIMEOUT=4, s_ack in the 4th s_cyc cycle -> normal ack with slave data, err_flag stays 0.
- Master 0 drops m_cyc after 1 BUSY cycle with no ack -> s_cyc falls, no m_ack, pending master 1 granted after one IDLE cycle.
- rst asserted while BUSY -> s_cyc=0 next cycle, the following grant goes to master 0 (last=M-1), err_flag=0.
